// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Used by the round-robin arbiter and by the top level.
package regfile_wb_ctrl_pkg;

  localparam int NREG = 32;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int IW   = $clog2(NREG);

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_t;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return a < AW'(NREG);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin arbiter between the ALU and LSU writeback requesters.
// The grant is combinational; the pointer only toggles after a contested grant.
module wb_rr_arbiter2
  import regfile_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_valid_alu,
  input  logic       i_valid_lsu,
  output logic [1:0] o_grant,
  output logic       o_rr_ptr
);

  wb_src_t r_rr_ptr;
  logic    w_contested;

  assign w_contested = i_valid_alu && i_valid_lsu;
  assign o_rr_ptr    = r_rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= WB_ALU;
    end else if (w_contested) begin
      r_rr_ptr <= (r_rr_ptr == WB_ALU) ? WB_LSU : WB_ALU;
    end
  end

  always_comb begin
    o_grant = 2'b00;
    if (w_contested) begin
      o_grant = (r_rr_ptr == WB_ALU) ? 2'b01 : 2'b10;
    end else begin
      o_grant = {i_valid_lsu, i_valid_alu};
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: arbitrates ALU/LSU writebacks onto one
// registered write port and keeps a pending scoreboard to stall RAW/WAW issue.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_src1,
  input  logic [AW-1:0]   issue_src2,
  input  logic [AW-1:0]   issue_dst,
  input  logic            issue_has_dst,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_data,
  output logic            lsu_ready,
  output logic            write_reg,
  output logic [AW-1:0]   dstreg_addr,
  output logic [DW-1:0]   dstreg_data,
  output logic [NREG-1:0] pending
);

  logic [1:0]      w_grant;
  logic            w_rr_ptr;
  logic            w_accept;
  logic            w_sel_lsu;
  logic [AW-1:0]   w_req_addr;
  logic [DW-1:0]   w_req_data;
  logic            w_req_write;
  logic            w_issue_set;
  logic [NREG-1:0] w_pend_nxt;

  logic            r_write_reg;
  logic [AW-1:0]   r_dstreg_addr;
  logic [DW-1:0]   r_dstreg_data;
  logic [NREG-1:0] r_pending;

  wb_rr_arbiter2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid_alu (alu_valid),
    .i_valid_lsu (lsu_valid),
    .o_grant     (w_grant),
    .o_rr_ptr    (w_rr_ptr)
  );

  assign alu_ready = w_grant[0];
  assign lsu_ready = w_grant[1];
  assign w_accept  = |w_grant;

  // Under contention the pointer names the winner; otherwise whoever is valid.
  assign w_sel_lsu   = lsu_valid && (!alu_valid || (w_rr_ptr == WB_LSU));
  assign w_req_addr  = w_sel_lsu ? lsu_addr : alu_addr;
  assign w_req_data  = w_sel_lsu ? lsu_data : alu_data;
  assign w_req_write = w_accept && addr_in_range(w_req_addr);

  // Out-of-range requests are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write_reg   <= 1'b0;
      r_dstreg_addr <= '0;
      r_dstreg_data <= '0;
    end else begin
      r_write_reg <= w_req_write;
      if (w_req_write) begin
        r_dstreg_addr <= w_req_addr;
        r_dstreg_data <= w_req_data;
      end
    end
  end

  function automatic logic pend_at(input logic [NREG-1:0] p, input logic [AW-1:0] a);
    return addr_in_range(a) ? p[a[IW-1:0]] : 1'b0;
  endfunction

  assign issue_stall = issue_valid &&
                       (pend_at(r_pending, issue_src1) ||
                        pend_at(r_pending, issue_src2) ||
                        (issue_has_dst && pend_at(r_pending, issue_dst)));

  assign w_issue_set = issue_valid && !issue_stall && issue_has_dst &&
                       addr_in_range(issue_dst);

  // Clear on commit first so a same-cycle set of the same bit wins.
  always_comb begin
    w_pend_nxt = r_pending;
    if (r_write_reg) begin
      w_pend_nxt[r_dstreg_addr[IW-1:0]] = 1'b0;
    end
    if (w_issue_set) begin
      w_pend_nxt[issue_dst[IW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

  assign write_reg   = r_write_reg;
  assign dstreg_addr = r_dstreg_addr;
  assign dstreg_data = r_dstreg_data;
  assign pending     = r_pending;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed-vector bench for regfile_wb_ctrl: a table of per-cycle stimulus with
// hand-computed expectations, followed by reset sequences.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic [AW-1:0]   issue_src1, issue_src2, issue_dst;
  logic            issue_has_dst;
  logic            issue_stall;
  logic            alu_valid;
  logic [AW-1:0]   alu_addr;
  logic [DW-1:0]   alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_data;
  logic            lsu_ready;
  logic            write_reg;
  logic [AW-1:0]   dstreg_addr;
  logic [DW-1:0]   dstreg_data;
  logic [NREG-1:0] pending;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_src1    (issue_src1),
    .issue_src2    (issue_src2),
    .issue_dst     (issue_dst),
    .issue_has_dst (issue_has_dst),
    .issue_stall   (issue_stall),
    .alu_valid     (alu_valid),
    .alu_addr      (alu_addr),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .lsu_valid     (lsu_valid),
    .lsu_addr      (lsu_addr),
    .lsu_data      (lsu_data),
    .lsu_ready     (lsu_ready),
    .write_reg     (write_reg),
    .dstreg_addr   (dstreg_addr),
    .dstreg_data   (dstreg_data),
    .pending       (pending)
  );

  typedef struct {
    logic        av;  logic [5:0] aa; logic [31:0] ad;
    logic        lv;  logic [5:0] la; logic [31:0] ld;
    logic        iv;  logic [5:0] s1; logic [5:0]  s2; logic [5:0] d; logic hd;
    logic        ear; logic elr; logic est;
    logic        ewr; logic cwp; logic [5:0] ea; logic [31:0] ed;
    logic [31:0] ep;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[24];

  function automatic vec_t mk(
    input logic av, input logic [5:0] aa, input logic [31:0] ad,
    input logic lv, input logic [5:0] la, input logic [31:0] ld,
    input logic iv, input logic [5:0] s1, input logic [5:0] s2,
    input logic [5:0] d, input logic hd,
    input logic ear, input logic elr, input logic est,
    input logic ewr, input logic cwp, input logic [5:0] ea, input logic [31:0] ed,
    input logic [31:0] ep);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.iv = iv; v.s1 = s1; v.s2 = s2; v.d = d; v.hd = hd;
    v.ear = ear; v.elr = elr; v.est = est;
    v.ewr = ewr; v.cwp = cwp; v.ea = ea; v.ed = ed; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    lsu_valid = v.lv; lsu_addr = v.la; lsu_data = v.ld;
    issue_valid = v.iv; issue_src1 = v.s1; issue_src2 = v.s2;
    issue_dst = v.d; issue_has_dst = v.hd;
    #1;
    chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(v.ear));
    chk($sformatf("v%0d_lsu_ready", i), 32'(lsu_ready), 32'(v.elr));
    chk($sformatf("v%0d_stall", i), 32'(issue_stall), 32'(v.est));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_write_reg", i), 32'(write_reg), 32'(v.ewr));
    chk($sformatf("v%0d_pending", i), pending, v.ep);
    if (v.cwp) begin
      chk($sformatf("v%0d_addr", i), 32'(dstreg_addr), 32'(v.ea));
      chk($sformatf("v%0d_data", i), dstreg_data, v.ed);
    end
  endtask

  initial begin
    //            av aa  ad      lv la  ld       iv s1  s2  d   hd  ar lr st  wr cw ea ed      pend
    vecs[0]  = mk(0, 0,  0,      0, 0,  0,       0, 0,  0,  0,  0,  0, 0, 0,  0, 1, 0, 0,      'h0);
    vecs[1]  = mk(1, 3,  'h11,   1, 4,  'h22,    0, 0,  0,  0,  0,  1, 0, 0,  1, 1, 3, 'h11,   'h0);
    vecs[2]  = mk(1, 3,  'h11,   1, 4,  'h22,    0, 0,  0,  0,  0,  0, 1, 0,  1, 1, 4, 'h22,   'h0);
    vecs[3]  = mk(1, 3,  'h11,   1, 4,  'h22,    0, 0,  0,  0,  0,  1, 0, 0,  1, 1, 3, 'h11,   'h0);
    vecs[4]  = mk(1, 3,  'h11,   1, 4,  'h22,    0, 0,  0,  0,  0,  0, 1, 0,  1, 1, 4, 'h22,   'h0);
    vecs[5]  = mk(0, 0,  0,      0, 0,  0,       1, 0,  0,  5,  1,  0, 0, 0,  0, 1, 4, 'h22,   'h20);
    vecs[6]  = mk(0, 0,  0,      0, 0,  0,       1, 5,  0,  0,  0,  0, 0, 1,  0, 1, 4, 'h22,   'h20);
    vecs[7]  = mk(1, 5,  'h55,   0, 0,  0,       1, 5,  0,  0,  0,  1, 0, 1,  1, 1, 5, 'h55,   'h20);
    vecs[8]  = mk(0, 0,  0,      0, 0,  0,       1, 5,  0,  0,  0,  0, 0, 1,  0, 1, 5, 'h55,   'h0);
    vecs[9]  = mk(0, 0,  0,      0, 0,  0,       1, 5,  0,  0,  0,  0, 0, 0,  0, 1, 5, 'h55,   'h0);
    vecs[10] = mk(0, 0,  0,      0, 0,  0,       1, 0,  0,  7,  1,  0, 0, 0,  0, 1, 5, 'h55,   'h80);
    vecs[11] = mk(0, 0,  0,      0, 0,  0,       1, 0,  0,  7,  1,  0, 0, 1,  0, 1, 5, 'h55,   'h80);
    vecs[12] = mk(0, 0,  0,      1, 7,  'h77,    1, 0,  0,  7,  1,  0, 1, 1,  1, 1, 7, 'h77,   'h80);
    vecs[13] = mk(0, 0,  0,      0, 0,  0,       1, 0,  0,  7,  1,  0, 0, 1,  0, 1, 7, 'h77,   'h0);
    vecs[14] = mk(0, 0,  0,      0, 0,  0,       1, 0,  0,  7,  1,  0, 0, 0,  0, 1, 7, 'h77,   'h80);
    vecs[15] = mk(1, 2,  'h2,    0, 0,  0,       0, 0,  0,  0,  0,  1, 0, 0,  1, 1, 2, 'h2,    'h80);
    vecs[16] = mk(0, 0,  0,      0, 0,  0,       1, 0,  0,  2,  1,  0, 0, 0,  0, 1, 2, 'h2,    'h84);
    vecs[17] = mk(0, 0,  0,      1, 40, 'hDEAD,  0, 0,  0,  0,  0,  0, 1, 0,  0, 0, 0, 0,      'h84);
    vecs[18] = mk(0, 0,  0,      0, 0,  0,       1, 40, 33, 50, 1,  0, 0, 0,  0, 0, 0, 0,      'h84);
    vecs[19] = mk(1, 7,  'h70,   1, 1,  'h01,    0, 0,  0,  0,  0,  1, 0, 0,  1, 1, 7, 'h70,   'h84);
    vecs[20] = mk(0, 0,  0,      1, 1,  'h01,    0, 0,  0,  0,  0,  0, 1, 0,  1, 1, 1, 'h01,   'h04);
    vecs[21] = mk(0, 0,  0,      0, 0,  0,       0, 0,  0,  0,  0,  0, 0, 0,  0, 1, 1, 'h01,   'h04);
    vecs[22] = mk(1, 8,  'h88,   1, 9,  'h99,    0, 0,  0,  0,  0,  0, 1, 0,  1, 1, 9, 'h99,   'h04);
    vecs[23] = mk(1, 8,  'h88,   0, 0,  0,       0, 0,  0,  0,  0,  1, 0, 0,  1, 1, 8, 'h88,   'h04);

    rst_n = 1'b0;
    issue_valid = 0; issue_src1 = '0; issue_src2 = '0; issue_dst = '0; issue_has_dst = 0;
    alu_valid = 1; alu_addr = 6'd3; alu_data = 32'h11;
    lsu_valid = 0; lsu_addr = '0; lsu_data = '0;
    @(negedge clk);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_write_reg", 32'(write_reg), 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_addr", 32'(dstreg_addr), 32'd0);
      chk("rst_data", dstreg_data, 32'd0);
    end
    rst_n = 1'b1;
    alu_valid = 0;

    for (int i = 0; i < 24; i++) apply(i, vecs[i]);

    // Reset while a hazard is outstanding and an r9 write is being accepted.
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0;
    issue_valid = 1; issue_src1 = '0; issue_src2 = '0; issue_dst = 6'd9; issue_has_dst = 1;
    @(posedge clk);
    #1;
    chk("mid_pending_set", pending, 32'h204);
    @(negedge clk);
    issue_valid = 0; issue_has_dst = 0;
    alu_valid = 1; alu_addr = 6'd9; alu_data = 32'h99;
    rst_n = 0;
    #1;
    chk("mid_alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_write_reg", 32'(write_reg), 32'd0);
    chk("mid_pending", pending, 32'd0);
    @(negedge clk);
    rst_n = 1; alu_valid = 0;
    @(posedge clk);
    #1;
    chk("post_write_reg", 32'(write_reg), 32'd0);
    chk("post_pending", pending, 32'd0);
    chk("post_addr", 32'(dstreg_addr), 32'd0);

    // After reset the pointer is back on the ALU.
    @(negedge clk);
    alu_valid = 1; alu_addr = 6'd10; alu_data = 32'hA;
    lsu_valid = 1; lsu_addr = 6'd11; lsu_data = 32'hB;
    #1;
    chk("post_alu_ready", 32'(alu_ready), 32'd1);
    chk("post_lsu_ready", 32'(lsu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("post_wr", 32'(write_reg), 32'd1);
    chk("post_wr_addr", 32'(dstreg_addr), 32'd10);
    chk("post_wr_data", dstreg_data, 32'hA);
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
